// File: rtl/ahb_slave_wbuf.sv
// AHB-Lite responder that turns each accepted beat into one valid/ready backend
// command; writes are posted through a single-entry buffer, reads block the bus.
module ahb_slave_wbuf #(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic                            HSEL,
  input  logic [AHB_ADDRESS_WIDTH-1:0]    HADDR,
  input  logic                            HWRITE,
  input  logic [2:0]                      HSIZE,
  input  logic [2:0]                      HBURST,
  input  logic [1:0]                      HTRANS,
  input  logic [AHB_DATA_WIDTH-1:0]       HWDATA,
  input  logic                            HREADY,
  output logic                            HREADYOUT,
  output logic                            HRESP,
  output logic [AHB_DATA_WIDTH-1:0]       HRDATA,
  output logic                            be_valid,
  input  logic                            be_ready,
  output logic                            be_write,
  output logic [AHB_ADDRESS_WIDTH-1:0]    be_addr,
  output logic [2:0]                      be_size,
  output logic [AHB_DATA_WIDTH/8-1:0]     be_strb,
  output logic [AHB_DATA_WIDTH-1:0]       be_wdata,
  input  logic                            be_rvalid,
  input  logic [AHB_DATA_WIDTH-1:0]       be_rdata
);

  localparam int STRB_W = AHB_DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [2:0] {
    DP_IDLE, DP_WR, DP_RD_REQ, DP_RD_RESP, DP_RD_DONE, DP_ERR1, DP_ERR2
  } state_t;

  state_t                         state_q, state_d;
  logic [AHB_ADDRESS_WIDTH-1:0]   dp_addr_q, dp_addr_d;
  logic [2:0]                     dp_size_q, dp_size_d;
  logic [STRB_W-1:0]              dp_strb_q, dp_strb_d;
  logic                           wb_full_q, wb_full_d;
  logic [AHB_ADDRESS_WIDTH-1:0]   wb_addr_q, wb_addr_d;
  logic [2:0]                     wb_size_q, wb_size_d;
  logic [STRB_W-1:0]              wb_strb_q, wb_strb_d;
  logic [AHB_DATA_WIDTH-1:0]      wb_data_q, wb_data_d;
  logic [AHB_DATA_WIDTH-1:0]      hrdata_q, hrdata_d;

  logic                           accept;
  logic                           addr_ok;
  logic                           ready_out;
  logic [7:0]                     align_mask;
  logic [STRB_W-1:0]              lane_strb;
  int                             lane_off;
  int                             lane_bytes;

  // Burst type and SEQ/NONSEQ distinction do not affect per-beat handling.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign accept = HSEL & HREADY & HTRANS[1];

  always_comb begin
    align_mask = (8'd1 << HSIZE) - 8'd1;
    addr_ok    = (HSIZE <= 3'(LANE_W)) && ((HADDR[6:0] & align_mask[6:0]) == 7'd0);
    lane_off   = int'(HADDR[LANE_W-1:0]);
    lane_bytes = 32'd1 << HSIZE;
    lane_strb  = '0;
    for (int i = 0; i < STRB_W; i++) begin
      lane_strb[i] = (i >= lane_off) && (i < lane_off + lane_bytes);
    end
  end

  always_comb begin
    case (state_q)
      DP_IDLE, DP_RD_DONE, DP_ERR2: ready_out = 1'b1;
      DP_WR:                        ready_out = !wb_full_q;
      default:                      ready_out = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dp_addr_d = dp_addr_q;
    dp_size_d = dp_size_q;
    dp_strb_d = dp_strb_q;
    wb_full_d = wb_full_q;
    wb_addr_d = wb_addr_q;
    wb_size_d = wb_size_q;
    wb_strb_d = wb_strb_q;
    wb_data_d = wb_data_q;
    hrdata_d  = hrdata_q;

    if (wb_full_q && be_ready) begin
      wb_full_d = 1'b0;
    end

    case (state_q)
      // A buffered write always goes out ahead of the read command.
      DP_RD_REQ: begin
        if (!wb_full_q && be_ready) begin
          state_d = DP_RD_RESP;
        end
      end
      DP_RD_RESP: begin
        if (be_rvalid) begin
          hrdata_d = be_rdata;
          state_d  = DP_RD_DONE;
        end
      end
      DP_ERR1: state_d = DP_ERR2;
      default: ;
    endcase

    // Completing data phase: capture write data and sample the next address phase.
    if (ready_out && HREADY) begin
      if (state_q == DP_WR) begin
        wb_full_d = 1'b1;
        wb_addr_d = dp_addr_q;
        wb_size_d = dp_size_q;
        wb_strb_d = dp_strb_q;
        wb_data_d = HWDATA;
      end
      if (accept) begin
        dp_addr_d = HADDR;
        dp_size_d = HSIZE;
        dp_strb_d = lane_strb;
        if (!addr_ok) begin
          state_d = DP_ERR1;
        end else if (HWRITE) begin
          state_d = DP_WR;
        end else begin
          state_d = DP_RD_REQ;
        end
      end else begin
        state_d = DP_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DP_IDLE;
      dp_addr_q <= '0;
      dp_size_q <= '0;
      dp_strb_q <= '0;
      wb_full_q <= 1'b0;
      wb_addr_q <= '0;
      wb_size_q <= '0;
      wb_strb_q <= '0;
      wb_data_q <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      dp_addr_q <= dp_addr_d;
      dp_size_q <= dp_size_d;
      dp_strb_q <= dp_strb_d;
      wb_full_q <= wb_full_d;
      wb_addr_q <= wb_addr_d;
      wb_size_q <= wb_size_d;
      wb_strb_q <= wb_strb_d;
      wb_data_q <= wb_data_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign HREADYOUT = ready_out;
  assign HRESP     = (state_q == DP_ERR1) || (state_q == DP_ERR2);
  assign HRDATA    = hrdata_q;

  always_comb begin
    be_valid = 1'b0;
    be_write = 1'b0;
    be_addr  = '0;
    be_size  = '0;
    be_strb  = '0;
    be_wdata = '0;
    if (wb_full_q) begin
      be_valid = 1'b1;
      be_write = 1'b1;
      be_addr  = wb_addr_q;
      be_size  = wb_size_q;
      be_strb  = wb_strb_q;
      be_wdata = wb_data_q;
    end else if (state_q == DP_RD_REQ) begin
      be_valid = 1'b1;
      be_addr  = dp_addr_q;
      be_size  = dp_size_q;
      be_strb  = dp_strb_q;
    end
  end

endmodule

// File: tb/tb_ahb_slave_wbuf.sv
// Scoreboard bench for ahb_slave_wbuf: a master driver pushes expected backend
// commands and bus responses; independent monitors pop and compare them.
module tb_ahb_slave_wbuf;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE, HBURST;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA, HRDATA;
  logic          be_valid, be_ready, be_write, be_rvalid;
  logic [AW-1:0] be_addr;
  logic [2:0]    be_size;
  logic [SW-1:0] be_strb;
  logic [DW-1:0] be_wdata, be_rdata;

  assign HREADY = HREADYOUT;

  ahb_slave_wbuf #(.AHB_DATA_WIDTH(DW), .AHB_ADDRESS_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .be_valid(be_valid), .be_ready(be_ready), .be_write(be_write), .be_addr(be_addr),
    .be_size(be_size), .be_strb(be_strb), .be_wdata(be_wdata),
    .be_rvalid(be_rvalid), .be_rdata(be_rdata)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [63:0] wdata;
    int          waits;
  } xfer_t;
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } be_cmd_t;
  typedef struct {
    bit          err;
    bit          write;
    logic [63:0] rdata;
    int          waits;
  } resp_t;

  xfer_t   stim_q[$];
  be_cmd_t be_exp_q[$];
  resp_t   resp_exp_q[$];

  int total = 0;
  int bad = 0;
  int be_hs_cnt = 0;
  int ready_pct = 100;
  int rv_max = 0;
  int hold_off = 0;
  bit spurious_en = 0;

  int          rd_wait = -1;
  logic [31:0] rd_addr = '0;
  bit          mon_dp_act = 0;
  int          mon_waits = 0;
  bit          mon_resp_or = 0;
  int          hs_base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_pattern(input logic [31:0] a);
    return {a ^ 32'hC0DE_5A5A, ~a};
  endfunction

  function automatic xfer_t mk(input bit sel, input logic [1:0] trans, input bit write,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [63:0] wdata, input int waits);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write; x.addr = addr; x.size = size;
    x.burst = 3'b011; x.wdata = wdata; x.waits = waits;
    return x;
  endfunction

  // Reference model: what the backend and the bus must show for one accepted beat.
  task automatic model_accept(input xfer_t x);
    int      nbytes;
    bit      err;
    be_cmd_t c;
    resp_t   r;
    nbytes = 1 << x.size;
    err = (nbytes > SW) || ((x.addr % 32'(nbytes)) != 0);
    if (!err) begin
      c.write = x.write;
      c.addr  = x.addr;
      c.size  = x.size;
      c.strb  = 8'(((1 << nbytes) - 1) << (x.addr % SW));
      c.wdata = x.write ? x.wdata : 64'd0;
      be_exp_q.push_back(c);
    end
    r.err = err; r.write = x.write; r.rdata = rd_pattern(x.addr); r.waits = x.waits;
    resp_exp_q.push_back(r);
  endtask

  task automatic drive_bus(input xfer_t ap, input xfer_t dp, input bit dp_busy);
    HSEL = ap.sel; HTRANS = ap.trans; HWRITE = ap.write; HADDR = ap.addr;
    HSIZE = ap.size; HBURST = ap.burst;
    HWDATA = (dp_busy && dp.write) ? dp.wdata : 64'hBAD0_BAD0_BAD0_BAD0;
  endtask

  task automatic run_stim(input int max_cycles);
    xfer_t ap, dp, idle_x;
    bit    rdy, dp_busy;
    int    cyc;
    idle_x = mk(0, 2'b00, 0, 32'd0, 3'd0, 64'd0, -1);
    ap = idle_x; dp = idle_x; dp_busy = 0; cyc = 0;
    @(posedge HCLK); #1;
    if (stim_q.size() != 0) ap = stim_q.pop_front();
    drive_bus(ap, dp, 0);
    forever begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      @(posedge HCLK); #1;
      if (rdy) begin
        dp_busy = ap.sel && ap.trans[1];
        if (dp_busy) begin
          model_accept(ap);
          dp = ap;
        end
        if (stim_q.size() != 0) ap = stim_q.pop_front();
        else ap = idle_x;
      end
      drive_bus(ap, dp, dp_busy);
      if (rdy && !dp_busy && !(ap.sel && ap.trans[1]) && stim_q.size() == 0) break;
      cyc++;
      if (cyc > max_cycles) begin
        chk("stim_timeout", 64'(cyc), 64'(max_cycles));
        stim_q.delete();
        drive_bus(idle_x, idle_x, 0);
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((be_exp_q.size() != 0 || resp_exp_q.size() != 0) && n < 300) begin
      @(posedge HCLK); #1;
      n++;
    end
    chk({nm, "_pending"}, 64'(be_exp_q.size() + resp_exp_q.size()), 64'd0);
    chk({nm, "_be_idle"}, 64'(be_valid), 64'd0);
  endtask

  // Backend model: random ready, read data some cycles after each read handshake.
  initial begin
    be_ready = 1'b0; be_rvalid = 1'b0; be_rdata = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        rd_wait = -1;
      end else if (be_valid && be_ready && !be_write) begin
        rd_wait = int'($urandom_range(0, rv_max));
        rd_addr = be_addr;
      end
      @(posedge HCLK); #1;
      be_rvalid = 1'b0;
      be_rdata  = {$urandom, $urandom};
      if (rd_wait == 0) begin
        be_rvalid = 1'b1;
        be_rdata  = rd_pattern(rd_addr);
        rd_wait   = -1;
      end else if (rd_wait > 0) begin
        rd_wait--;
      end else if (spurious_en && $urandom_range(0, 5) == 0) begin
        be_rvalid = 1'b1;
      end
      if (hold_off > 0) begin
        be_ready = 1'b0;
        hold_off--;
      end else begin
        be_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
    end
  end

  // Backend monitor: every presented command must match the head of the queue.
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn && be_valid) begin
        if (be_exp_q.size() == 0) begin
          chk("be_unexpected_valid", 64'(be_valid), 64'd0);
        end else begin
          chk("be_write", 64'(be_write), 64'(be_exp_q[0].write));
          chk("be_addr",  64'(be_addr),  64'(be_exp_q[0].addr));
          chk("be_size",  64'(be_size),  64'(be_exp_q[0].size));
          chk("be_strb",  64'(be_strb),  64'(be_exp_q[0].strb));
          chk("be_wdata", be_wdata,      be_exp_q[0].wdata);
          if (be_ready) begin
            void'(be_exp_q.pop_front());
            be_hs_cnt++;
          end
        end
      end
    end
  end

  // Bus response monitor: tracks data phases from the bus and checks completion.
  initial begin
    resp_t r;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        mon_dp_act = 0; mon_waits = 0; mon_resp_or = 0;
      end else begin
        if (mon_dp_act) begin
          if (!HREADYOUT) begin
            mon_waits++;
            mon_resp_or = mon_resp_or | HRESP;
          end else if (resp_exp_q.size() == 0) begin
            chk("resp_unexpected", 64'(mon_dp_act), 64'd0);
          end else begin
            r = resp_exp_q.pop_front();
            chk("hresp", 64'(HRESP), 64'(r.err));
            if (!r.err && !r.write) chk("hrdata", HRDATA, r.rdata);
            if (r.err) chk("err_waits", 64'(mon_waits), 64'd1);
            chk("wait_hresp", 64'(mon_resp_or), 64'(r.err));
            if (r.waits >= 0) chk("waits", 64'(mon_waits), 64'(r.waits));
            mon_waits = 0;
            mon_resp_or = 0;
          end
        end
        if (HREADYOUT) mon_dp_act = HSEL && HTRANS[1];
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    be_cmd_t c;
    HRESETn = 1'b0; HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HADDR = '0;
    HSIZE = '0; HBURST = '0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp", 64'(HRESP), 64'd0);
    chk("rst_hrdata", HRDATA, 64'd0);
    chk("rst_be_valid", 64'(be_valid), 64'd0);
    chk("rst_be_fields", {be_write, be_size, be_strb, be_addr}, 64'd0);
    chk("rst_be_wdata", be_wdata, 64'd0);
    HRESETn = 1'b1;

    // Single posted write on empty buffer: zero wait states.
    stim_q.push_back(mk(1, 2'b10, 1, 32'h4, 3'd2, 64'h11223344_00000000, 0));
    run_stim(100);
    drain("single_wr");

    // INCR4 word writes with backend stalled at first.
    hold_off = 3;
    hs_base = be_hs_cnt;
    stim_q.push_back(mk(1, 2'b10, 1, 32'h0, 3'd2, 64'h0000_0000_A000_0000, 0));
    stim_q.push_back(mk(1, 2'b11, 1, 32'h4, 3'd2, 64'hA111_1111_0000_0000, -1));
    stim_q.push_back(mk(1, 2'b11, 1, 32'h8, 3'd2, 64'h0000_0000_A222_2222, -1));
    stim_q.push_back(mk(1, 2'b11, 1, 32'hC, 3'd2, 64'hA333_3333_0000_0000, -1));
    run_stim(200);
    drain("incr4_wr");
    chk("incr4_hs", 64'(be_hs_cnt - hs_base), 64'd4);

    // Blocking doubleword read, immediate backend: two wait states.
    stim_q.push_back(mk(1, 2'b10, 0, 32'h8, 3'd3, 64'd0, 2));
    run_stim(100);
    drain("single_rd");

    // Write then read same address with backend stalled: write must lead.
    hold_off = 4;
    stim_q.push_back(mk(1, 2'b10, 1, 32'h10, 3'd3, 64'h0123_4567_89AB_CDEF, 0));
    stim_q.push_back(mk(1, 2'b10, 0, 32'h10, 3'd3, 64'd0, -1));
    run_stim(200);
    drain("wr_rd");

    // Misaligned halfword and oversize transfer: two-cycle ERROR, no backend.
    hs_base = be_hs_cnt;
    stim_q.push_back(mk(1, 2'b10, 1, 32'h1, 3'd1, 64'hFFFF, 1));
    stim_q.push_back(mk(0, 2'b00, 0, 32'h0, 3'd0, 64'd0, -1));
    stim_q.push_back(mk(1, 2'b10, 0, 32'h0, 3'd4, 64'd0, 1));
    run_stim(100);
    drain("errors");
    chk("err_hs", 64'(be_hs_cnt - hs_base), 64'd0);

    // INCR4 with a BUSY slot: still exactly four commands.
    hs_base = be_hs_cnt;
    stim_q.push_back(mk(1, 2'b10, 1, 32'h40, 3'd2, 64'h0000_0000_B000_0000, 0));
    stim_q.push_back(mk(1, 2'b11, 1, 32'h44, 3'd2, 64'hB111_1111_0000_0000, -1));
    stim_q.push_back(mk(1, 2'b01, 1, 32'h48, 3'd2, 64'd0, -1));
    stim_q.push_back(mk(1, 2'b11, 1, 32'h48, 3'd2, 64'h0000_0000_B222_2222, -1));
    stim_q.push_back(mk(1, 2'b11, 0, 32'h4C, 3'd2, 64'd0, -1));
    run_stim(200);
    drain("busy_incr4");
    chk("busy_hs", 64'(be_hs_cnt - hs_base), 64'd4);

    // Randomized traffic with backpressure and stray read-valid pulses.
    ready_pct = 60; rv_max = 3; spurious_en = 1;
    for (int i = 0; i < 300; i++) begin
      xfer_t x;
      int    r, a, sz;
      r  = int'($urandom_range(0, 99));
      sz = int'($urandom_range(0, 4));
      a  = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) != 0) a = a & ~((1 << sz) - 1);
      x.sel   = (r >= 5);
      x.trans = (r < 12) ? 2'b00 : (r < 20) ? 2'b01 : ($urandom_range(0, 1) != 0 ? 2'b10 : 2'b11);
      x.write = ($urandom_range(0, 1) != 0);
      x.addr  = 32'(a);
      x.size  = 3'(sz);
      x.burst = 3'($urandom_range(0, 7));
      x.wdata = {$urandom, $urandom};
      x.waits = -1;
      stim_q.push_back(x);
    end
    run_stim(8000);
    drain("random");
    ready_pct = 100; rv_max = 0; spurious_en = 0;

    // Reset asserted while a read is stalled at the backend.
    hold_off = 1000;
    @(posedge HCLK); #1;
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h8; HSIZE = 3'd3;
    c.write = 0; c.addr = 32'h8; c.size = 3'd3; c.strb = 8'hFF; c.wdata = 64'd0;
    be_exp_q.push_back(c);
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk("midrd_stall", 64'(HREADYOUT), 64'd0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrd_rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("midrd_rst_hresp", 64'(HRESP), 64'd0);
    chk("midrd_rst_hrdata", HRDATA, 64'd0);
    chk("midrd_rst_be_valid", 64'(be_valid), 64'd0);
    be_exp_q.delete();
    resp_exp_q.delete();
    repeat (3) @(posedge HCLK);
    #1;
    hold_off = 0;
    HRESETn = 1'b1;
    chk("post_rst_hreadyout", 64'(HREADYOUT), 64'd1);
    stim_q.push_back(mk(1, 2'b10, 1, 32'h20, 3'd3, 64'hFEED_FACE_0BAD_BEEF, 0));
    stim_q.push_back(mk(1, 2'b10, 0, 32'h20, 3'd3, 64'd0, -1));
    run_stim(200);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_slave_wbuf.md
Name: ahb_slave_wbuf

Overview:
- AHB-Lite slave (responder) front end of the bridge. It accepts NONSEQ/SEQ transfers and returns wait states and OKAY/ERROR responses.
- Each accepted beat becomes one command on a simple valid/ready backend port.
- Writes are posted through a 1-entry write buffer; reads are blocking.
- Write-before-read ordering is preserved at the backend.

Parameters:
- AHB_DATA_WIDTH, 64, HWDATA/HRDATA/be data width in bits (32, 64 or 128).
- AHB_ADDRESS_WIDTH, 32, HADDR/be_addr width.

Ports:
- HCLK  input  1  bus clock, all logic on rising edge
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  slave select
- HADDR  input  AHB_ADDRESS_WIDTH  address-phase address
- HWRITE  input  1  1 = write
- HSIZE  input  3  transfer size, bytes = 2**HSIZE
- HBURST  input  3  burst type; ignored, each beat handled independently
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWDATA  input  AHB_DATA_WIDTH  write data (data phase)
- HREADY  input  1  bus ready from interconnect
- HREADYOUT  output  1  slave ready
- HRESP  output  1  0 OKAY, 1 ERROR
- HRDATA  output  AHB_DATA_WIDTH  read data, registered
- be_valid  output  1  backend command valid
- be_ready  input  1  backend accepts command
- be_write  output  1  command is write
- be_addr  output  AHB_ADDRESS_WIDTH  byte address
- be_size  output  3  HSIZE of command
- be_strb  output  AHB_DATA_WIDTH/8  byte-lane enables
- be_wdata  output  AHB_DATA_WIDTH  write data
- be_rvalid  input  1  read data valid (one-cycle pulse)
- be_rdata  input  AHB_DATA_WIDTH  read data

Behaviour:
- Reset (HRESETn=0, async):
  - HREADYOUT=1, HRESP=0, HRDATA=0, be_valid=0, be_write=0, be_addr/be_size/be_strb/be_wdata=0.
  - Write buffer empty; FSM=DP_IDLE.
  - Reset mid-transfer abandons the in-flight beat and flushes the write buffer.
- Address phase accepted on a rising edge when HSEL & HREADY & HTRANS[1]=1. HADDR/HWRITE/HSIZE are registered into data-phase regs.
- IDLE, BUSY or HSEL=0 with HREADY=1: next state DP_IDLE (zero-wait OKAY, no backend activity).
- Error check at acceptance:
  - HSIZE > log2(AHB_DATA_WIDTH/8), or HADDR not aligned to 2**HSIZE, gives next state DP_ERR1.
  - Otherwise next state is DP_WR (write) or DP_RD_REQ (read).
- Byte lanes: off = HADDR mod (AHB_DATA_WIDTH/8); strb bits [off, off+2**HSIZE-1] = 1, all others 0.
- FSM states:
  - DP_IDLE: HREADYOUT=1, HRESP=0; samples the next address phase.
  - DP_WR:
    - HREADYOUT = !wbuf_full.
    - When HREADYOUT=1 the edge loads wbuf with {addr, size, strb, HWDATA} and samples the next address phase (pipelined, no bubble).
    - When HREADYOUT=0, stays in DP_WR; the master holds HWDATA.
  - wbuf:
    - While full, drives be_valid=1, be_write=1 with stored fields.
    - Empties on the edge where be_valid & be_ready.
    - Load and drain in the same cycle are not possible (HREADYOUT=0 while full).
  - DP_RD_REQ:
    - HREADYOUT=0.
    - If wbuf full, the buffered write is presented first.
    - Once wbuf is empty, drives be_valid=1, be_write=0, be_addr/be_size/be_strb from data-phase regs, be_wdata=0.
    - be_ready goes to DP_RD_RESP.
  - DP_RD_RESP: HREADYOUT=0, be_valid=0. be_rvalid latches be_rdata into HRDATA and goes to DP_RD_DONE.
  - DP_RD_DONE: HREADYOUT=1, HRESP=0, HRDATA valid; samples the next address phase.
  - DP_ERR1: HREADYOUT=0, HRESP=1. Next state is DP_ERR2.
  - DP_ERR2:
    - HREADYOUT=1, HRESP=1.
    - Samples the next address phase; HTRANS is ignored if the master cancels with IDLE.
    - No backend command is issued for an errored beat.
- Latency:
  - A write with empty wbuf has 0 wait states; be_valid rises the cycle after the data-phase edge.
  - A read with be_ready=1 and be_rvalid in the first RD_RESP cycle has 2 wait states.
- HRDATA holds its last value outside DP_RD_DONE.
- be_rvalid outside DP_RD_RESP is ignored.
- be_* fields are stable while be_valid=1 and be_ready=0.

Test Plan:
- Reset: HRESETn low for 3 cycles, asserted mid-read → HREADYOUT=1, HRESP=0, HRDATA=0, be_valid=0; FSM recovers to DP_IDLE.
- Single write, 64-bit bus, HADDR=0x4, HSIZE=010, HWDATA=0x11223344_00000000, be_ready=1 → 0 wait states; next cycle be_valid=1, be_write=1, be_addr=0x4, be_strb=0xF0.
- INCR4 word writes from 0x0, be_ready=0 for first 3 cycles → beat0 zero-wait; beat1 data phase HREADYOUT=0 until the wbuf drain edge; strbs 0x0F, 0xF0, 0x0F, 0xF0 in order; exactly 4 be handshakes.
- Read HADDR=0x8, HSIZE=011, be_ready=1, be_rvalid=1 with be_rdata=0xDEADBEEF_CAFEF00D in the first RD_RESP cycle → HREADYOUT low 2 cycles, then HRDATA=0xDEADBEEF_CAFEF00D with HRESP=0.
- Write 0x10 then read 0x10 back-to-back, be_ready low 4 cycles → backend sees write before read; read be_valid only after the write handshake.
- Halfword at HADDR=0x1, and separately HSIZE=100 → HREADYOUT 0 then 1 with HRESP=1 both cycles; no be_valid.
- BUSY inserted mid-INCR4 → BUSY cycle gives zero-wait OKAY and no backend command; beat count stays 4.
